// File: rtl/uart_pkg.sv
// Shared definitions for the UART family: default sizes, clog2 helper and the
// baud configuration record.
package uart_pkg;

  localparam int unsigned CNT_W_DEF      = 13;
  localparam int unsigned FRAC_W_DEF     = 3;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [CNT_W_DEF-1:0]  baud_val;
    logic [FRAC_W_DEF-1:0] baud_frac;
  } baud_cfg_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Configuration and strobe bundle between the register block (master) and the
// baud generator (slave).
interface uart_baud_gen_if
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
);
  // Minimum width of 1 keeps baud_frac legal when the fractional logic is disabled.
  localparam int unsigned FW = (FRAC_W > 0) ? FRAC_W : 1;

  logic          en;
  logic [CNT_W-1:0] baud_val;
  logic [FW-1:0] baud_frac;
  logic          phase_clr;
  logic          baud_clock;
  logic          xmit_pulse;
  logic          rx_sample;

  modport master (
    output en, baud_val, baud_frac, phase_clr,
    input  baud_clock, xmit_pulse, rx_sample
  );

  modport slave (
    input  en, baud_val, baud_frac, phase_clr,
    output baud_clock, xmit_pulse, rx_sample
  );

endinterface

// File: rtl/uart_frac_acc.sv
// Fractional-divisor accumulator: each reload adds frac and, on carry, arms a
// one-clock stall that stretches the following period.
module uart_frac_acc #(
  parameter int unsigned FRAC_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              reload,
  input  logic [FRAC_W-1:0] frac,
  output logic              stall
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stall_q, stall_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    acc_d   = acc_q;
    stall_d = stall_q;
    sum     = {1'b0, acc_q} + {1'b0, frac};
    if (!en) begin
      acc_d   = '0;
      stall_d = 1'b0;
    end else if (reload) begin
      // A pending stall consumes this zero-count edge instead of reloading.
      if (stall_q) begin
        stall_d = 1'b0;
      end else begin
        acc_d   = sum[FRAC_W-1:0];
        stall_d = sum[FRAC_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate generator: integer down-counter with fractional stretch, oversample
// tick, bit-rate pulse and mid-bit receive strobe.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned FRAC_W     = FRAC_W_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input logic            clk,
  input logic            reset,
  uart_baud_gen_if.slave bus
);

  localparam int unsigned     PH_W   = clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PhLast = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PhMid  = PH_W'(OVERSAMPLE / 2 - 1);

  logic [CNT_W-1:0] cntr_q, cntr_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             baud_clock_q, baud_clock_d;
  logic             at_zero;
  logic             reload;
  logic             stall;

  assign at_zero = (cntr_q == '0);
  assign reload  = bus.en & at_zero;

  if (FRAC_W > 0) begin : g_frac
    uart_frac_acc #(
      .FRAC_W (FRAC_W)
    ) u_frac_acc (
      .clk    (clk),
      .reset  (reset),
      .en     (bus.en),
      .reload (reload),
      .frac   (bus.baud_frac[FRAC_W-1:0]),
      .stall  (stall)
    );
  end else begin : g_no_frac
    assign stall = 1'b0;
  end

  always_comb begin
    cntr_d       = cntr_q;
    ph_d         = ph_q;
    baud_clock_d = 1'b0;
    if (!bus.en) begin
      cntr_d = '0;
      ph_d   = '0;
    end else begin
      if (!at_zero) begin
        cntr_d = cntr_q - 1'b1;
      end else if (!stall) begin
        baud_clock_d = 1'b1;
        cntr_d       = bus.baud_val;
      end
      // Clear wins over an advance on the same edge.
      if (bus.phase_clr) begin
        ph_d = '0;
      end else if (baud_clock_q) begin
        ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cntr_q       <= '0;
      ph_q         <= '0;
      baud_clock_q <= 1'b0;
    end else begin
      cntr_q       <= cntr_d;
      ph_q         <= ph_d;
      baud_clock_q <= baud_clock_d;
    end
  end

  assign bus.baud_clock = baud_clock_q;
  assign bus.xmit_pulse = baud_clock_q & (ph_q == PhLast);
  assign bus.rx_sample  = baud_clock_q & (ph_q == PhMid);

endmodule
